// File: rtl/div_nb.sv
// Sequential restoring divider, WIDTH-bit signed/unsigned, inicio/fim handshake.
// Latency WIDTH+1 edges from accept (1 edge on divide-by-zero); inicio ignored while busy.
module div_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             fim,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dv, a_hold;
  logic             neg_q, neg_r, dz;

  // Sign-extend by one bit so the most negative operand has a representable magnitude.
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sh;
  logic             ge;

  assign a_ext = {signed_mode & A[WIDTH-1], A};
  assign b_ext = {signed_mode & B[WIDTH-1], B};
  assign a_mag = a_ext[WIDTH] ? WIDTH'(-a_ext) : a_ext[WIDTH-1:0];
  assign b_mag = b_ext[WIDTH] ? WIDTH'(-b_ext) : b_ext[WIDTH-1:0];

  // Shifted partial remainder needs one extra bit when the divisor uses the full width.
  assign sh = {rem, quo[WIDTH-1]};
  assign ge = (sh >= {1'b0, dv});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (inicio) state_nx = (B == '0) ? FINISH : RUN;
      RUN:     if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dv        <= '0;
      a_hold    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      fim       <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fim <= 1'b0;
          if (inicio) begin
            busy   <= 1'b1;
            a_hold <= A;
            dv     <= b_mag;
            quo    <= a_mag;
            rem    <= '0;
            neg_q  <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= signed_mode & A[WIDTH-1];
            dz     <= (B == '0);
            cnt    <= (B == '0) ? '0 : CW'(WIDTH);
          end
        end
        RUN: begin
          if (ge) begin
            rem <= sh[WIDTH-1:0] - dv;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          fim      <= 1'b1;
          busy     <= 1'b0;
          div_zero <= dz;
          if (dz) begin
            quociente <= '1;
            resto     <= a_hold;
          end else begin
            quociente <= neg_q ? -quo : quo;
            resto     <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nb.sv
// Bench for div_nb: WIDTH=8 and WIDTH=16 instances checked every cycle against a latency/arithmetic model.
module tb_div_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ini8 = 1'b0, sm8 = 1'b0, ini16 = 1'b0, sm16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic        fim8, busy8, dz8, fim16, busy16, dz16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  div_nb #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .inicio(ini8), .signed_mode(sm8), .A(a8), .B(b8),
    .quociente(q8), .resto(r8), .fim(fim8), .busy(busy8), .div_zero(dz8)
  );

  div_nb #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .inicio(ini16), .signed_mode(sm16), .A(a16), .B(b16),
    .quociente(q16), .resto(r16), .fim(fim16), .busy(busy16), .div_zero(dz16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer division (C truncation for signed operands).
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sm, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
    longint m, sa, sb;
    m = (longint'(1) << w) - 1;
    if (b == 0) begin
      q  = 32'(m);
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
      sa = longint'(a);
      sb = longint'(b);
      if (sm) begin
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
      end
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
    end
  endfunction

  // Transaction model: result appears WIDTH+1 edges after accept (1 edge for B=0).
  int          m_cnt [2];
  logic [31:0] m_q [2], m_r [2], p_q [2], p_r [2];
  logic        m_dz [2], p_dz [2], m_fim [2];

  always @(posedge clk or posedge rst) begin : model
    int          w;
    logic        ini, sm;
    logic [31:0] a, b;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0; m_q[d] = '0; m_r[d] = '0; m_dz[d] = 1'b0; m_fim[d] = 1'b0;
        p_q[d] = '0; p_r[d] = '0; p_dz[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        w   = (d == 1) ? 16 : 8;
        ini = (d == 1) ? ini16 : ini8;
        sm  = (d == 1) ? sm16 : sm8;
        a   = (d == 1) ? {16'b0, a16} : {24'b0, a8};
        b   = (d == 1) ? {16'b0, b16} : {24'b0, b8};
        m_fim[d] = 1'b0;
        if (m_cnt[d] > 0) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_q[d] = p_q[d]; m_r[d] = p_r[d]; m_dz[d] = p_dz[d]; m_fim[d] = 1'b1;
          end
        end else if (ini) begin
          ref_div(w, a, b, sm, p_q[d], p_r[d], p_dz[d]);
          m_cnt[d] = (b == 0) ? 1 : w + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("fim8",   fim8,  m_fim[0]);
    chk("busy8",  busy8, m_cnt[0] > 0);
    chk("q8",     q8,    m_q[0]);
    chk("r8",     r8,    m_r[0]);
    chk("dz8",    dz8,   m_dz[0]);
    chk("fim16",  fim16, m_fim[1]);
    chk("busy16", busy16, m_cnt[1] > 0);
    chk("q16",    q16,   m_q[1]);
    chk("r16",    r16,   m_r[1]);
    chk("dz16",   dz16,  m_dz[1]);
  end

  task automatic drive(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic ini);
    if (d == 1) begin
      a16 = a[15:0]; b16 = b[15:0]; sm16 = sm; ini16 = ini;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; ini8 = ini;
    end
  endtask

  // Counts edges until fim is seen; lat enters holding edges already elapsed since accept.
  task automatic wait_fim(input int d, inout int lat);
    logic f;
    f = 1'b0;
    while (!f && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      f = (d == 1) ? fim16 : fim8;
    end
    if (!f) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_fim timeout: no fim on dut%0d within %0d edges", d, lat);
    end
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic sm, output int lat);
    @(posedge clk); #1;
    drive(d, a, b, sm, 1'b1);
    @(posedge clk); #1;
    drive(d, ~a, ~b, ~sm, 1'b0);
    lat = 0;
    wait_fim(d, lat);
  endtask

  initial begin : main
    int          lat, nf;
    logic [31:0] tq, tr, ra, rb;
    logic        tdz, rs;
    int          sel;

    ref_div(8, 200, 7, 1'b0, tq, tr, tdz);
    chk("pin_u_q", tq, 28); chk("pin_u_r", tr, 4); chk("pin_u_dz", tdz, 0);
    ref_div(8, 'hF9, 'h02, 1'b1, tq, tr, tdz);
    chk("pin_s_q", tq, 'hFD); chk("pin_s_r", tr, 'hFF);
    ref_div(8, 'h80, 'hFF, 1'b1, tq, tr, tdz);
    chk("pin_ovf_q", tq, 'h80); chk("pin_ovf_r", tr, 'h00);
    ref_div(8, 'h55, 0, 1'b1, tq, tr, tdz);
    chk("pin_dz_q", tq, 'hFF); chk("pin_dz_r", tr, 'h55); chk("pin_dz", tdz, 1);
    ref_div(16, 65535, 255, 1'b0, tq, tr, tdz);
    chk("pin_w16_q", tq, 257); chk("pin_w16_r", tr, 0);

    @(posedge clk); #1;
    chk("rst_q", q8, 0); chk("rst_r", r8, 0); chk("rst_fim", fim8, 0);
    chk("rst_busy", busy8, 0); chk("rst_dz", dz8, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(0, 200, 7, 1'b0, lat);
    chk("u_lat", lat, 9); chk("u_q", q8, 28); chk("u_r", r8, 4); chk("u_dz", dz8, 0);
    @(posedge clk); #1;
    chk("u_fim_len", fim8, 0); chk("u_q_hold", q8, 28);

    run_op(0, 'hF9, 'h02, 1'b1, lat);
    chk("s_q", q8, 'hFD); chk("s_r", r8, 'hFF);
    run_op(0, 'h80, 'hFF, 1'b1, lat);
    chk("ovf_q", q8, 'h80); chk("ovf_r", r8, 'h00);

    run_op(0, 'h55, 0, 1'b0, lat);
    chk("dz_u_lat", lat, 1); chk("dz_u_q", q8, 'hFF); chk("dz_u_r", r8, 'h55); chk("dz_u", dz8, 1);
    run_op(0, 'h55, 0, 1'b1, lat);
    chk("dz_s_lat", lat, 1); chk("dz_s_q", q8, 'hFF); chk("dz_s_r", r8, 'h55); chk("dz_s", dz8, 1);
    run_op(0, 9, 3, 1'b0, lat);
    chk("dz_clr_q", q8, 3); chk("dz_clr_r", r8, 0); chk("dz_clr", dz8, 0);

    // inicio pulsed at E3 of a running operation must be ignored
    @(posedge clk); #1;
    drive(0, 200, 7, 1'b0, 1'b1);
    @(posedge clk); #1;
    ini8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 drive(0, 9, 3, 1'b0, 1'b1);
    @(posedge clk); #1;
    ini8 = 1'b0;
    lat = 3;
    wait_fim(0, lat);
    chk("busy_lat", lat, 9); chk("busy_q", q8, 28); chk("busy_r", r8, 4);
    nf = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fim8) nf++;
    end
    chk("busy_no_2nd_fim", nf, 0);

    // inicio held during the fim cycle starts a new operation on the next edge
    run_op(0, 200, 7, 1'b0, lat);
    drive(0, 9, 3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("b2b_busy", busy8, 1); chk("b2b_fim_fall", fim8, 0);
    ini8 = 1'b0;
    lat = 0;
    wait_fim(0, lat);
    chk("b2b_lat", lat, 9); chk("b2b_q", q8, 3); chk("b2b_r", r8, 0);

    // reset asserted mid-operation
    @(posedge clk); #1;
    drive(0, 200, 7, 1'b0, 1'b1);
    @(posedge clk); #1;
    ini8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_q", q8, 0); chk("mid_rst_r", r8, 0); chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_fim", fim8, 0); chk("mid_rst_dz", dz8, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nf = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fim8) nf++;
    end
    chk("mid_rst_no_fim", nf, 0);

    run_op(1, 65535, 255, 1'b0, lat);
    chk("w16_lat", lat, 17); chk("w16_q", q16, 257); chk("w16_r", r16, 0);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      if (sel == 0) rb = 0;
      if (sel == 1) ra = 32'h8000;
      if (sel == 2) rb = 32'hFFFF;
      if (sel == 3) rb = 1;
      run_op(1, ra, rb, rs, lat);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      if (sel == 0) rb = 0;
      if (sel == 1) ra = 32'h80;
      if (sel == 2) rb = 32'hFF;
      run_op(0, ra, rb, rs, lat);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
